inst_rom_loader: RTL and testbench

//  Writer side of the instruction ROM: receives a program as a byte stream and writes it into the ROM

---
 rtl/inst_rom_loader_pkg.sv | 21 ++
 rtl/inst_rom_loader_byte_packer.sv | 34 +++
 rtl/inst_rom_loader.sv | 108 ++++++++++
 tb/tb_inst_rom_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared state encoding and stream framing constants for the ROM loader
package inst_rom_loader_pkg;

  localparam int LOADER_LEN_BYTES  = 2;
  localparam int LOADER_WORD_BYTES = 4;
  localparam int LEN_W             = LOADER_LEN_BYTES * 8;
  localparam int WORD_W            = LOADER_WORD_BYTES * 8;
  localparam int CNT_W             = $clog2(LOADER_WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LOADER_WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// rtl/inst_rom_loader_byte_packer.sv - big-endian byte-to-word assembler with byte count and full flag
module inst_rom_loader_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  // First byte of a word ends up in the top byte after LOADER_WORD_BYTES shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (shift_en) begin
      word  <= {word[WORD_W-9:0], data};
      count <= count + CNT_W'(1);
      if (count == LAST_BYTE) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - streams a length-prefixed program image into the instruction ROM, then releases the core
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Capacity at LEN_W+1 bits so a full ROM (2**16 words) still compares correctly.
  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_WIDTH;

  state_t                  state;
  state_t                  next;
  logic [7:0]              len_hi;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        word_cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LEN_W-1:0]        len_full;
  logic                    xfer;
  logic                    start_ok;
  logic                    last_word;
  logic [CNT_W-1:0]        pk_count;
  logic                    pk_full;

  assign xfer      = byte_valid & byte_ready;
  assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign len_full  = {len_hi, byte_data};
  assign last_word = ({1'b0, word_cnt} + (LEN_W + 1)'(1)) == {1'b0, len};
  assign mem_addr  = addr;

  inst_rom_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok | pk_full),
    .shift_en (xfer & (state == S_DATA)),
    .data     (byte_data),
    .word     (mem_wdata),
    .count    (pk_count),
    .full     (pk_full)
  );

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next = S_LEN_HI;
      S_LEN_HI: if (xfer) next = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == '0)                  next = S_DONE;
          else if ({1'b0, len_full} > CAPACITY) next = S_ERROR;
          else                                  next = S_DATA;
        end
      end
      S_DATA:  if (xfer && pk_count == LAST_BYTE) next = S_WRITE;
      S_WRITE: next = last_word ? S_DONE : S_DATA;
      default: next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      len_hi     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      addr       <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next;
      byte_ready <= (next == S_LEN_HI) | (next == S_LEN_LO) | (next == S_DATA);
      mem_we     <= (next == S_WRITE);
      cpu_rst    <= (next != S_DONE);
      busy       <= (next == S_LEN_HI) | (next == S_LEN_LO) | (next == S_DATA) | (next == S_WRITE);
      done       <= (next == S_DONE);
      error      <= (next == S_ERROR);
      if (start_ok) begin
        addr     <= '0;
        word_cnt <= '0;
      end
      if (state == S_LEN_HI && xfer) len_hi <= byte_data;
      if (state == S_LEN_LO && xfer) len    <= len_full;
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + LEN_W'(1);
        if (!last_word) addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - table-driven and scoreboarded bench for the instruction ROM loader
module tb_inst_rom_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  typedef struct { int n; bit gaps; bit fixed; } img_t;
  img_t tbl[7];

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 0);
    check({tag, "_mem_we"},     32'(mem_we), 0);
    check({tag, "_mem_addr"},   32'(mem_addr), 0);
    check({tag, "_mem_wdata"},  mem_wdata, 0);
    check({tag, "_cpu_rst"},    32'(cpu_rst), 1);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_done"},       32'(done), 0);
    check({tag, "_error"},      32'(error), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  t;
    bit  rdy;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    do begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) check("byte_accept_timeout", 0, 1);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input bit gaps);
    exp_t e;
    e.addr = a;
    e.data = w;
    sb_q.push_back(e);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gaps);
  endtask

  task automatic wait_end(input int bound, output int cycles);
    int t;
    t = 0;
    while (!(done || error) && t < bound) begin
      @(negedge clk);
      t++;
    end
    cycles = t;
    check("end_reached_in_bound", 32'(done | error), 1);
  endtask

  task automatic load(input int n, input bit gaps, input bit fixed);
    logic [31:0] w;
    int cyc;
    do_start();
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    if (n > CAP) begin
      @(negedge clk);
      check("err_error", 32'(error), 1);
      check("err_cpu_rst", 32'(cpu_rst), 1);
      check("err_byte_ready", 32'(byte_ready), 0);
      check("err_done", 32'(done), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = fixed ? 32'h3C020404 : $urandom;
      send_word(AW'(i), w, gaps);
    end
    wait_end(10, cyc);
    if (n == 0) check("len0_done_within_2", 32'(cyc <= 2), 1);
    @(negedge clk);
    check("end_done", 32'(done), 1);
    check("end_cpu_rst", 32'(cpu_rst), 0);
    check("end_busy", 32'(busy), 0);
    check("end_byte_ready", 32'(byte_ready), 0);
    check("end_error", 32'(error), 0);
    check("sb_drained", 32'(sb_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] w;
    int cyc;
    tbl[0] = '{n: 1,  gaps: 1'b0, fixed: 1'b1};
    tbl[1] = '{n: 3,  gaps: 1'b1, fixed: 1'b0};
    tbl[2] = '{n: 0,  gaps: 1'b0, fixed: 1'b0};
    tbl[3] = '{n: 17, gaps: 1'b0, fixed: 1'b0};
    tbl[4] = '{n: 16, gaps: 1'b0, fixed: 1'b0};
    tbl[5] = '{n: 16, gaps: 1'b1, fixed: 1'b0};
    tbl[6] = '{n: 2,  gaps: 1'b0, fixed: 1'b0};

    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) load(tbl[k].n, tbl[k].gaps, tbl[k].fixed);

    // Asynchronous reset in the middle of word 1 of a 4-word image.
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(AW'(0), 32'hA5A5_0001, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    load(2, 1'b0, 1'b0);

    // start pulsed during DATA is ignored; start after DONE restarts from address 0.
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(AW'(0), 32'h1111_2222, 1'b0);
    w = 32'h3333_4444;
    begin
      exp_t e;
      e.addr = AW'(1);
      e.data = w;
      sb_q.push_back(e);
    end
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    do_start();
    check("start_in_data_busy", 32'(busy), 1);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
    send_word(AW'(2), 32'h5555_6666, 1'b0);
    wait_end(10, cyc);
    check("restart_pre_done", 32'(done), 1);
    check("restart_sb_drained", 32'(sb_q.size()), 0);
    @(posedge clk); #1;
    do_start();
    check("restart_cpu_rst", 32'(cpu_rst), 1);
    check("restart_done", 32'(done), 0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(AW'(0), 32'h7777_8888, 1'b0);
    wait_end(10, cyc);
    check("reload_done", 32'(done), 1);
    check("reload_sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
